power_ramp_pwm: RTL and testbench
=================================

# power_ramp_pwm

Drives one chassis power actuator from the configuration decoder's `chs_power[3:0]` level and `chs_mode` enable, which this block consumes directly downstream. It converts the 4-bit requested level into a 16-slot PWM waveform. It soft-ramps the applied level one step at a time so loads never see a sudden power jump. Level changes take effect only at PWM period boundaries, so every period is glitch-free.

## Interface
Parameters:
- `PRESC`, default 2: clock cycles per PWM tick; legal values ≥1.
- `RAMP_STEP`, default 2: PWM periods per one-level ramp step; legal values ≥1.

Ports:
- `clk`, input, 1 bit: single clock for the block.
- `rst`, input, 1 bit: reset; synchronous, active-high.
- `chs_power`, input, 4 bits: requested power level, 0–15.
- `chs_mode`, input, 1 bit: 1 = powered (target = `chs_power`), 0 = standby (target = 0).
- `pwm_out`, output, 1 bit: registered PWM drive.
- `cur_level`, output, 4 bits: currently applied level.
- `busy`, output, 1 bit: high while in state RAMP_UP or RAMP_DOWN.
- `period_start`, output, 1 bit: one-cycle pulse on the cycle after each period boundary.

## Operation
- Prescaler `presc_cnt` counts 0..PRESC-1. `tick` = (`presc_cnt` == PRESC-1).
- `pwm_cnt` (4 bits) increments on `tick` and wraps 15→0.
- Boundary = `tick` && `pwm_cnt` == 15.
- `target` = `chs_mode` ? `chs_power` : 0.
  - Sampled only at a boundary.
  - Input changes between boundaries are ignored; the last value present at the boundary wins.
- At each boundary, `cur_level` is compared with the freshly sampled `target`:
  - Equal: `ramp_cnt` ← 0 and `cur_level` holds.
  - Different and `ramp_cnt` == RAMP_STEP-1: `cur_level` steps ±1 toward `target` and `ramp_cnt` ← 0.
  - Different otherwise: `ramp_cnt` increments.
  - Direction reversal (target crosses to the other side of `cur_level`): `ramp_cnt` ← 0 before counting.
- State is registered and updated at the boundary from the post-step values:
  - IDLE: `cur_level` == 0 and `target` == 0.
  - RAMP_UP: `target` > `cur_level`.
  - RAMP_DOWN: `target` < `cur_level`.
  - HOLD: `cur_level` == `target` ≠ 0.
- `pwm_out` ← (`pwm_cnt` < `cur_level`) every cycle. Output therefore lags the counter by one cycle.
- Duty is `cur_level`/16: level 0 gives constant low; level 15 gives 15 of 16 slots high.
- Level arithmetic is 4-bit unsigned and saturates. No step ever passes 0 or 15 (guaranteed by stepping toward an in-range target).

## Timing
- Reset values:
  - Counters: `presc_cnt`, `pwm_cnt`, `ramp_cnt` = 0.
  - Outputs: `cur_level` = 0, `pwm_out` = 0, `busy` = 0, `period_start` = 0.
  - Internal: state = IDLE, `target` = 0.
- First boundary is on cycle 16·PRESC-1 after reset deasserts (cycles counted from 0). With PRESC=2 that is cycle 31.
- `cur_level` changes in the cycle after the boundary. `pwm_out` reflects the new level from the first slot of the new period.
- Latency from a new target to the first level step: at most one period plus RAMP_STEP periods.
- `rst` asserted mid-ramp or mid-period returns everything to reset values on the next edge. No partial period is emitted afterwards.
- `chs_mode` falling mid-ramp-up: at the next boundary the target becomes 0, the direction reverses, and the block ramps down.

## Structure
- Shared package `power_pkg` holds:
  - State encoding: IDLE=2'd0, RAMP_UP=2'd1, RAMP_DOWN=2'd2, HOLD=2'd3.
  - `PWM_BITS`=4 and `PWM_SLOTS`=16.
- Sub-module `pwm_tick_gen` contains the prescaler and `pwm_cnt`. It outputs `tick`, `pwm_cnt` and `boundary`.
- The top level holds the target sampling, the ramp counter, the FSM and the output registers.

## Test plan
All scenarios use PRESC=2, RAMP_STEP=2.
- Reset, then hold `chs_mode`=1, `chs_power`=4:
  - `busy`=1 after the first boundary.
  - `cur_level` steps 1, 2, 3, 4 at boundaries 2, 4, 6, 8 (`cur_level` reaches 4 by cycle 256).
  - State becomes HOLD and `busy`=0.
- At level 4, set `chs_power`=15 and `chs_mode`=1:
  - `cur_level` reaches 15 after 22 further periods.
  - `pwm_out` is high for 30 of every 32 cycles.
- At level 8, drop `chs_mode` to 0:
  - State becomes RAMP_DOWN and the level falls to 0.
  - State ends IDLE with `pwm_out` constant 0.
- While ramping up from 2 toward 10, change `chs_power` to 0 mid-period:
  - No step occurs in that period.
  - At the next boundary `ramp_cnt` clears and the state becomes RAMP_DOWN.
- Toggle `chs_power` between boundaries, ending at 6 just before the boundary: the sampled target is 6.
- Assert `rst` for one cycle at level 9, mid-period: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/power_pkg.sv
// Shared types and level helpers for the chassis power ramp PWM block.
package power_pkg;

    localparam int PWM_BITS  = 4;
    localparam int PWM_SLOTS = 16;

    localparam logic [PWM_BITS-1:0] LEVEL_ZERO = 4'd0;
    localparam logic [PWM_BITS-1:0] LEVEL_ONE  = 4'd1;
    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = 4'd15;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } ramp_state_e;

    // One saturating step of the applied level toward the target.
    function automatic logic [PWM_BITS-1:0] step_toward(
        input logic [PWM_BITS-1:0] level,
        input logic [PWM_BITS-1:0] target
    );
        logic [PWM_BITS-1:0] next_level;
        if ((target > level) && (level != LEVEL_MAX)) begin
            next_level = level + LEVEL_ONE;
        end else if ((target < level) && (level != LEVEL_ZERO)) begin
            next_level = level - LEVEL_ONE;
        end else begin
            next_level = level;
        end
        return next_level;
    endfunction

    function automatic ramp_state_e classify(
        input logic [PWM_BITS-1:0] level,
        input logic [PWM_BITS-1:0] target
    );
        ramp_state_e st;
        if (target > level) begin
            st = RAMP_UP;
        end else if (target < level) begin
            st = RAMP_DOWN;
        end else if (level == LEVEL_ZERO) begin
            st = IDLE;
        end else begin
            st = HOLD;
        end
        return st;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler and 16-slot PWM slot counter; flags the last tick of every period.
module pwm_tick_gen
    import power_pkg::*;
#(
    parameter int PRESC = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                tick,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                boundary
);

    localparam int              PC_W       = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PC_W-1:0] PRESC_LAST = PC_W'(PRESC - 1);
    localparam logic [PC_W-1:0] PRESC_ONE  = PC_W'(1);

    logic [PC_W-1:0]     presc_cnt_q;
    logic [PC_W-1:0]     presc_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic                tick_s;

    // Next-count logic; the slot counter wraps 15 -> 0 naturally.
    always_comb begin
        tick_s      = (presc_cnt_q == PRESC_LAST);
        presc_cnt_d = presc_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        if (tick_s) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = pwm_cnt_q + LEVEL_ONE;
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

    assign tick     = tick_s;
    assign pwm_cnt  = pwm_cnt_q;
    assign boundary = tick_s && (pwm_cnt_q == LEVEL_MAX);

endmodule

// File: rtl/power_ramp_pwm.sv
// Soft-ramped PWM drive for one chassis power actuator; level changes land only on period boundaries.
module power_ramp_pwm
    import power_pkg::*;
#(
    parameter int PRESC     = 2,
    parameter int RAMP_STEP = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] chs_power,
    input  logic                chs_mode,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] cur_level,
    output logic                busy,
    output logic                period_start
);

    localparam int              RC_W      = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
    localparam logic [RC_W-1:0] RAMP_LAST = RC_W'(RAMP_STEP - 1);
    localparam logic [RC_W-1:0] RAMP_ONE  = RC_W'(1);

    logic                tick_unused_s;
    logic [PWM_BITS-1:0] pwm_cnt_s;
    logic                boundary_s;

    logic [PWM_BITS-1:0] target_q,       target_d;
    logic [PWM_BITS-1:0] cur_level_q,    cur_level_d;
    logic [RC_W-1:0]     ramp_cnt_q,     ramp_cnt_d;
    ramp_state_e         state_q,        state_d;
    logic                pwm_out_q,      pwm_out_d;
    logic                busy_q,         busy_d;
    logic                period_start_q, period_start_d;

    logic [PWM_BITS-1:0] sampled_s;
    logic                reversal_s;
    logic [RC_W-1:0]     ramp_base_s;

    pwm_tick_gen #(
        .PRESC (PRESC)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick_unused_s),
        .pwm_cnt  (pwm_cnt_s),
        .boundary (boundary_s)
    );

    // Target sampling, ramp pacing and state update, all gated by the period boundary.
    always_comb begin
        target_d       = target_q;
        cur_level_d    = cur_level_q;
        ramp_cnt_d     = ramp_cnt_q;
        state_d        = state_q;
        pwm_out_d      = (pwm_cnt_s < cur_level_q);
        period_start_d = boundary_s;

        sampled_s   = chs_mode ? chs_power : LEVEL_ZERO;
        // The previous target records which side of the level we were ramping toward.
        reversal_s  = ((target_q > cur_level_q) && (sampled_s < cur_level_q)) ||
                      ((target_q < cur_level_q) && (sampled_s > cur_level_q));
        ramp_base_s = reversal_s ? '0 : ramp_cnt_q;

        if (boundary_s) begin
            target_d = sampled_s;
            if (sampled_s == cur_level_q) begin
                ramp_cnt_d = '0;
            end else if (ramp_base_s == RAMP_LAST) begin
                cur_level_d = step_toward(cur_level_q, sampled_s);
                ramp_cnt_d  = '0;
            end else begin
                ramp_cnt_d = ramp_base_s + RAMP_ONE;
            end
            state_d = classify(cur_level_d, sampled_s);
        end else begin
            target_d = target_q;
        end

        case (state_d)
            RAMP_UP:   busy_d = 1'b1;
            RAMP_DOWN: busy_d = 1'b1;
            IDLE:      busy_d = 1'b0;
            HOLD:      busy_d = 1'b0;
            default:   busy_d = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q       <= LEVEL_ZERO;
            cur_level_q    <= LEVEL_ZERO;
            ramp_cnt_q     <= '0;
            state_q        <= IDLE;
            pwm_out_q      <= 1'b0;
            busy_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            target_q       <= target_d;
            cur_level_q    <= cur_level_d;
            ramp_cnt_q     <= ramp_cnt_d;
            state_q        <= state_d;
            pwm_out_q      <= pwm_out_d;
            busy_q         <= busy_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign cur_level    = cur_level_q;
    assign busy         = busy_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_power_ramp_pwm.sv
// Scoreboard bench for power_ramp_pwm (PRESC=2, RAMP_STEP=2): expected level/busy/duty per period.
module tb_power_ramp_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] chs_power = 4'd0;
    logic       chs_mode = 1'b0;
    logic       pwm_out;
    logic [3:0] cur_level;
    logic       busy;
    logic       period_start;

    always #5 clk = ~clk;

    power_ramp_pwm #(
        .PRESC     (2),
        .RAMP_STEP (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .chs_power    (chs_power),
        .chs_mode     (chs_mode),
        .pwm_out      (pwm_out),
        .cur_level    (cur_level),
        .busy         (busy),
        .period_start (period_start)
    );

    typedef struct {
        int cur;
        int busy;
        int highs;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   prev_cur = -1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One PWM period: p0 at its start, p1 at slot 8, p2 one cycle before the boundary cycle.
    task automatic run_row(input int mode, input int p0, input int p1, input int p2,
                           input int cur, input int bsy);
        exp_t e;
        int   off;
        chs_mode  = mode[0];
        chs_power = p0[3:0];
        e.cur   = cur;
        e.busy  = bsy;
        e.highs = (prev_cur < 0) ? -1 : 2 * prev_cur;
        exp_q.push_back(e);
        prev_cur = cur;
        off = 0;
        do begin
            @(negedge clk);
            off++;
            if (off == 16) chs_power = p1[3:0];
            if (off == 30) chs_power = p2[3:0];
        end while (!period_start && off < 64);
        check("period_len", off, 32);
    endtask

    // Steady request from an idle/hold start: one level step every two periods.
    task automatic ramp_rows(input int mode, input int power, input int start, input int n);
        int tgt;
        int cur;
        tgt = (mode != 0) ? power : 0;
        for (int i = 1; i <= n; i++) begin
            if (start < tgt) cur = (start + i / 2 > tgt) ? tgt : start + i / 2;
            else             cur = (start - i / 2 < tgt) ? tgt : start - i / 2;
            run_row(mode, power, power, power, cur, (cur != tgt) ? 1 : 0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cur_level", cur_level, 0);
        check("rst_pwm_out", pwm_out, 0);
        check("rst_busy", busy, 0);
        check("rst_period_start", period_start, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        prev_cur = -1;
    endtask

    task automatic mid_reset();
        chs_mode  = 1'b1;
        chs_power = 4'd9;
        repeat (10) @(negedge clk);
        check("pwm_before_reset", pwm_out, 1);
        check("cur_before_reset", cur_level, 9);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        prev_cur = -1;
    endtask

    // Monitor: every period_start pops one expectation and checks level, busy and high-slot count.
    initial begin
        int   highs;
        exp_t e;
        highs = 0;
        forever begin
            @(negedge clk);
            if (period_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_period", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cur_level", cur_level, e.cur);
                    check("busy", busy, e.busy);
                    if (e.highs >= 0) check("pwm_high_cycles", highs, e.highs);
                end
                highs = pwm_out ? 1 : 0;
            end else begin
                highs += pwm_out ? 1 : 0;
            end
        end
    end

    initial begin
        do_reset();
        ramp_rows(1, 4, 0, 9);
        ramp_rows(1, 15, 4, 24);
        ramp_rows(1, 8, 15, 16);
        ramp_rows(0, 8, 8, 18);
        ramp_rows(1, 2, 0, 4);
        run_row(1, 10, 10, 10, 2, 1);
        run_row(1, 10, 0, 0, 2, 1);
        run_row(1, 0, 0, 0, 1, 1);
        run_row(1, 0, 0, 0, 1, 1);
        run_row(1, 0, 0, 0, 0, 0);
        run_row(1, 5, 9, 0, 0, 0);
        ramp_rows(1, 6, 0, 13);
        run_row(1, 9, 2, 6, 6, 0);
        ramp_rows(1, 9, 6, 6);
        mid_reset();
        ramp_rows(1, 3, 0, 3);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
